// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between up to eight clients and the rr_arbiter8.
// master: client side (drives req); slave: arbiter side (drives grant info).
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with registered one-hot
// grant plus encoded owner index. A grant is held until the owner drops its
// request; every release is followed by a one-cycle IDLE bubble.
// Optional hold limit: define RR_ARB_TIMEOUT_EN to revoke an ownership after
// MAX_HOLD consecutive grant cycles (timeout pulses for one cycle).
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave bus
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   g;
  logic [N_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic               grant_valid_q;

  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  logic       timeout_q;
`else
  wire unused_max_hold = ^32'(MAX_HOLD);
`endif

  // Pick the first requester at or after ptr, wrapping modulo 8.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[ptr + IDX_W'(k)]) begin
        win_idx = ptr + IDX_W'(k);
        win_any = 1'b1;
      end
    end
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      g             <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_any) begin
            state         <= GRANT;
            g             <= win_idx;
            grant_q       <= N_REQ'(1) << win_idx;
            grant_idx_q   <= win_idx;
            grant_valid_q <= 1'b1;
            ptr           <= win_idx + IDX_W'(1);
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt      <= '0;
`endif
          end
        end
        GRANT: begin
          if (!bus.req[g]) begin
            state         <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
          end else if (hold_cnt == HOLD_LAST) begin
            state         <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b1;
          end else begin
            hold_cnt      <= hold_cnt + 8'd1;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule
